// File: rtl/div_sequencer_pkg.sv
// div_sequencer_pkg
// Shared definitions for the iterative divider:
//   DIV_ITER  - number of shift-subtract iterations (equals operand width)
//   DATA_W    - operand / result width
//   state_t   - sequencer states IDLE, BUSY, DONE
//   abs_val() - two's-complement magnitude, returned as an unsigned value
package div_sequencer_pkg;

    localparam int DIV_ITER = 32;
    localparam int DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Magnitude of a value known to be negative when neg=1. The result is
    // read as unsigned, so 0x80000000 maps onto itself and needs no special case.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                  input logic              neg);
        return neg ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step
// One restoring shift-subtract iteration, purely combinational.
//   rem_in   - partial remainder (always < divisor)
//   quo_in   - dividend/quotient shift register; its MSB is the next dividend bit
//   divisor  - unsigned divisor magnitude
//   rem_out  - updated partial remainder
//   quo_out  - shift register with the new quotient bit appended at the LSB
module div_step
    import div_sequencer_pkg::*;
(
    input  logic [DATA_W-1:0] rem_in,
    input  logic [DATA_W-1:0] quo_in,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic [DATA_W-1:0] quo_out
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    always_comb begin
        shifted = {rem_in, quo_in[DATA_W-1]};
        diff    = shifted - {1'b0, divisor};
        // shifted < 2*divisor, so the top bit of diff is a clean borrow flag.
        if (!diff[DATA_W]) begin
            rem_out = diff[DATA_W-1:0];
            quo_out = {quo_in[DATA_W-2:0], 1'b1};
        end else begin
            rem_out = shifted[DATA_W-1:0];
            quo_out = {quo_in[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer
// Multi-cycle DIV/DIVU unit for the execute stage. Stalls the front of the
// pipeline while a restoring divider runs DIV_ITER iterations on operand
// magnitudes, then applies the sign fix-up and pulses done (HI/LO write).
//   clk, rst     - clock, synchronous active-high reset
//   start        - DIV/DIVU in execute; is_signed, a, b sampled with it
//   cancel       - execute-stage flush, aborts in any state
//   stall        - freezes fetch/decode/execute
//   done         - one-cycle result-valid pulse
//   quotient     - LO result, remainder - HI result
//   div_by_zero  - sampled divisor was zero
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int DIV_ITER = div_sequencer_pkg::DIV_ITER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        stall,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    localparam int CNT_W = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [31:0]       rem_reg, quo_reg, dvsr_reg;
    logic              neg_q_reg, neg_r_reg;
    // res_* hold the freshly finished result shown during DONE; out_* hold the
    // last committed result. A cancel in DONE therefore never disturbs out_*.
    logic [31:0]       res_q_reg, res_r_reg, out_q_reg, out_r_reg;
    logic              res_z_reg, out_z_reg;
    logic [31:0]       step_rem, step_quo;
    logic              accept;

    assign accept = (state_reg == IDLE) && start && !cancel;

    div_step u_step (
        .rem_in  (rem_reg),
        .quo_in  (quo_reg),
        .divisor (dvsr_reg),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (b == 32'd0) ? DONE : BUSY;
                    stall      = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_reg == CNT_LAST) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
                done       = !cancel;
            end
            default: state_next = IDLE;
        endcase
        if (cancel) state_next = IDLE;
        if (rst) begin
            stall = 1'b0;
            done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            dvsr_reg  <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            res_q_reg <= '0;
            res_r_reg <= '0;
            res_z_reg <= 1'b0;
            out_q_reg <= '0;
            out_r_reg <= '0;
            out_z_reg <= 1'b0;
        end else begin
            if (accept) begin
                cnt_reg   <= '0;
                rem_reg   <= '0;
                quo_reg   <= abs_val(a, is_signed & a[31]);
                dvsr_reg  <= abs_val(b, is_signed & b[31]);
                neg_q_reg <= is_signed & (a[31] ^ b[31]);
                neg_r_reg <= is_signed & a[31];
                if (b == 32'd0) begin
                    res_q_reg <= '1;
                    res_r_reg <= a;
                    res_z_reg <= 1'b1;
                end
            end
            if (state_reg == BUSY && !cancel) begin
                rem_reg <= step_rem;
                quo_reg <= step_quo;
                cnt_reg <= cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    res_q_reg <= neg_q_reg ? (32'd0 - step_quo) : step_quo;
                    res_r_reg <= neg_r_reg ? (32'd0 - step_rem) : step_rem;
                    res_z_reg <= 1'b0;
                end
            end
            if (state_reg == DONE && !cancel) begin
                out_q_reg <= res_q_reg;
                out_r_reg <= res_r_reg;
                out_z_reg <= res_z_reg;
            end
        end
    end

    always_comb begin
        if (state_reg == DONE) begin
            quotient    = res_q_reg;
            remainder   = res_r_reg;
            div_by_zero = res_z_reg;
        end else begin
            quotient    = out_q_reg;
            remainder   = out_r_reg;
            div_by_zero = out_z_reg;
        end
    end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter DIV_ITER, default 32, iteration count equal to the operand width.
REQ-002 SHALL have port clk  input  1  single pipeline clock, rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  a DIV/DIVU instruction is in the execute stage.
REQ-005 SHALL have port is_signed  input  1  1 selects DIV, 0 selects DIVU; sampled with start.
REQ-006 SHALL have port a  input  32  dividend; sampled with start.
REQ-007 SHALL have port b  input  32  divisor; sampled with start.
REQ-008 SHALL have port cancel  input  1  execute-stage flush; aborts the operation.
REQ-009 SHALL have port stall  output  1  freezes the fetch, decode and execute stages.
REQ-010 SHALL have port done  output  1  one-cycle pulse; the HI/LO write enable.
REQ-011 SHALL have port quotient  output  32  result destined for LO.
REQ-012 SHALL have port remainder  output  32  result destined for HI.
REQ-013 SHALL have port div_by_zero  output  1  set with done when the sampled b was 0.

Function
REQ-014 SHALL implement the states IDLE, BUSY and DONE.
REQ-015 IDLE: start=1, cancel=0, b!=0 SHALL latch the operands and go to BUSY with the iteration counter at 0.
REQ-016 IDLE: start=1, cancel=0, b==0 SHALL go directly to DONE.
REQ-017 BUSY SHALL perform one restoring shift-subtract step per cycle on the absolute values, so a shift-subtract iterative divider is the required architecture.
REQ-018 BUSY SHALL go to DONE after DIV_ITER cycles; counter wrap from DIV_ITER-1 SHALL be the exit condition.
REQ-019 DONE SHALL return to IDLE unconditionally after one cycle; start SHALL be ignored while in DONE.
REQ-020 stall SHALL be combinational: (IDLE & start & !cancel) | BUSY; stall SHALL be 0 in DONE, so the instruction advances on that edge.
REQ-021 done SHALL equal DONE & !cancel; quotient, remainder and div_by_zero SHALL be valid in that same cycle.
REQ-022 Latency: start sampled at cycle T SHALL give done at T+DIV_ITER+1 and stall high for T..T+DIV_ITER; divide-by-zero SHALL give done at T+1 and stall high at T only.
REQ-023 Signed mode: quotient sign SHALL be sign(a)^sign(b), remainder sign SHALL equal sign(a), and the magnitudes SHALL be handled as 32-bit unsigned so that 0x80000000 needs no special case.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0.
REQ-025 Divide by zero SHALL give quotient 0xFFFFFFFF, remainder equal to a, and div_by_zero=1.
REQ-026 cancel SHALL take priority in every state: next state IDLE, no done pulse, and quotient/remainder unchanged.
REQ-027 quotient, remainder and div_by_zero SHALL hold their values until the next accepted start.
REQ-028 start and cancel in the same IDLE cycle SHALL NOT be accepted, and stall SHALL stay 0.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, counter 0, quotient 0, remainder 0 and div_by_zero 0.
REQ-030 While rst=1, stall and done SHALL be 0.
REQ-031 Reset mid-BUSY SHALL discard the operation with no done pulse.

Structure
REQ-032 A shared package SHALL hold the state enumeration (IDLE/BUSY/DONE) and the constant DIV_ITER=32.
REQ-033 One combinational sub-module, div_step, SHALL perform a single restoring iteration: partial remainder and quotient in, updated pair out.
REQ-034 Sign fix-up and the operand absolute values SHALL live in div_sequencer.

Verification
REQ-035 DIVU 100/7 at T -> stall high T..T+32, done at T+33, quotient 14, remainder 2.
REQ-036 DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF, done after 33 cycles.
REQ-037 DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_by_zero 0.
REQ-038 DIVU 5/0 -> done at T+1, div_by_zero 1, quotient 0xFFFFFFFF, remainder 5.
REQ-039 cancel at T+10 of a BUSY operation -> stall low at T+11, no done, outputs keep their previous result; a new start at T+11 is accepted.
REQ-040 rst at T+5 mid-BUSY -> all outputs 0 next cycle and no done through T+40.
